// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// aluop codes and the control word produced by the state decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; irwrite/pcwrite/branch are gated in the top.
  typedef struct packed {
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
  } ctrl_word_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-word decoder for the multicycle controller.
module mc_outdec
  import mips_pkg::*;
(
  input  mc_state_t  state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    unique case (state)
      FETCH: begin
        cw.alusrcb = SRCB_FOUR;
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
      end
      DECODE: cw.alusrcb = SRCB_IMMSH;
      MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      MEMRD: cw.iord = 1'b1;
      MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      BRANCH: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      ADDIWB: cw.regwrite = 1'b1;
      JUMP: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic, and the
// mem_ready / zero / reset gating applied to the decoded control word.
module mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal_op
);

  mc_state_t  state_q, state_d;
  ctrl_word_t cw;
  logic       is_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        if      (op == OP_LW || op == OP_SW) state_d = MEMADR;
        else if (op == OP_RTYPE)             state_d = EXECUTE;
        else if (op == OP_BEQ)               state_d = BRANCH;
        else if (op == OP_ADDI)              state_d = ADDIEX;
        else if (op == OP_J)                 state_d = JUMP;
        else                                 state_d = FETCH;
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state (state_q),
    .cw    (cw)
  );

  assign is_fetch = (state_q == FETCH);

  // rst_n gates the enables combinationally so they drop mid-cycle on reset.
  assign memwrite   = rst_n & cw.memwrite;
  assign regwrite   = rst_n & cw.regwrite;
  assign irwrite    = rst_n & cw.irwrite & mem_ready;
  assign pcen       = rst_n & ((cw.pcwrite & (~is_fetch | mem_ready)) |
                               (cw.branch & zero));
  assign illegal_op = rst_n & (state_q == DECODE) & ~is_legal_op(op);

  assign iord     = cw.iord;
  assign regdst   = cw.regdst;
  assign memtoreg = cw.memtoreg;
  assign alusrca  = cw.alusrca;
  assign alusrcb  = cw.alusrcb;
  assign pcsrc    = cw.pcsrc;
  assign aluop    = cw.aluop;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: each instruction is expanded into its list of
// phases and every cycle's outputs are compared with the expected control word.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       pcen, illegal_op;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Phases of instruction execution, one per controller cycle.
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MWR = 5,
                 P_EX = 6, P_AWB = 7, P_BR = 8, P_IEX = 9, P_IWB = 10, P_J = 11;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Word layout: memwrite irwrite regwrite iord regdst memtoreg alusrca
  //              alusrcb[2] pcsrc[2] aluop[2] pcen illegal_op
  function automatic logic [14:0] mk(input logic mw, irw, rw, id, rd, m2r, sa,
                                     input logic [1:0] sb, ps, ao,
                                     input logic pe, il);
    return {mw, irw, rw, id, rd, m2r, sa, sb, ps, ao, pe, il};
  endfunction

  function automatic logic [14:0] got_word();
    return {memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca,
            alusrcb, pcsrc, aluop, pcen, illegal_op};
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [14:0] exp_word(input int p, input logic mr, z,
                                           input logic [5:0] o);
    case (p)
      P_F:   return mk(0, mr, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, mr, 0);
      P_D:   return mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, !legal(o));
      P_MA:  return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      P_MR:  return mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_MWB: return mk(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_MWR: return mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_EX:  return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0, 0);
      P_AWB: return mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_BR:  return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, z, 0);
      P_IEX: return mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      P_IWB: return mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      P_J:   return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [14:0] got, exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive inputs, check just before the posedge, advance.
  task automatic step(input int p, input logic mr, z, input logic [5:0] o);
    op = o; mem_ready = mr; zero = z;
    #4;
    check($sformatf("phase%0d_op%b", p, o), got_word(), exp_word(p, mr, z, o));
    @(negedge clk);
  endtask

  // waits < 0 picks random memory wait cycles; otherwise exact wait count.
  task automatic run_instr(input logic [5:0] o, input logic z, input int waits);
    int ph[$];
    int w;
    ph = {P_F, P_D};
    if (o == 6'b100011)      ph = {ph, P_MA, P_MR, P_MWB};
    else if (o == 6'b101011) ph = {ph, P_MA, P_MWR};
    else if (o == 6'b000000) ph = {ph, P_EX, P_AWB};
    else if (o == 6'b000100) ph = {ph, P_BR};
    else if (o == 6'b001000) ph = {ph, P_IEX, P_IWB};
    else if (o == 6'b000010) ph = {ph, P_J};
    foreach (ph[i]) begin
      if (ph[i] == P_F) begin
        w = int'($urandom_range(0, 1));
        repeat (w) step(P_F, 1'b0, z, o);
        step(P_F, 1'b1, z, o);
      end else if (ph[i] == P_MR || ph[i] == P_MWR) begin
        w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
        repeat (w) step(ph[i], 1'b0, z, o);
        step(ph[i], 1'b1, z, o);
      end else begin
        step(ph[i], 1'($urandom_range(0, 1)), z, o);
      end
    end
  endtask

  logic [5:0] ops [6];
  logic [5:0] ro;

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'b100011; zero = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    check("reset_word", got_word(), mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'b100011, 1'b0, 0);       // lw, no waits
    run_instr(6'b101011, 1'b0, 2);       // sw, two MEMWR waits
    run_instr(6'b000100, 1'b1, -1);      // beq taken
    run_instr(6'b000100, 1'b0, -1);      // beq not taken
    run_instr(6'b000000, 1'b0, -1);      // R-type
    run_instr(6'b001000, 1'b0, -1);      // addi
    run_instr(6'b111111, 1'b0, -1);      // illegal
    run_instr(6'b000010, 1'b0, -1);      // j
    run_instr(6'b100011, 1'b1, 2);       // lw with MEMRD waits

    for (int k = 0; k < 60; k++) begin
      ro = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      run_instr(ro, 1'($urandom_range(0, 1)), -1);
    end

    // Asynchronous reset while stalled in MEMWR.
    step(P_F, 1'b1, 1'b0, 6'b101011);
    step(P_D, 1'b0, 1'b0, 6'b101011);
    step(P_MA, 1'b0, 1'b0, 6'b101011);
    step(P_MWR, 1'b0, 1'b0, 6'b101011);
    mem_ready = 1'b0;
    #2;
    check("memwr_before_rst", {14'b0, memwrite}, 15'd1);
    rst_n = 1'b0;
    #1;
    check("memwr_async_drop", {14'b0, memwrite}, 15'd0);
    check("async_rst_word", got_word(), mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'b000010, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
